// File: rtl/ua280_reset_pkg.sv
// Shared encodings for the ua280 reset sequencer: FSM states, reset causes, width helper.
package ua280_reset_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_AREQ = 2'd1,
    CAUSE_SW   = 2'd2
  } cause_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ua280_sync_bit.sv
// Multi-stage single-bit synchroniser; sync reset drives every stage to 1 (request active).
module ua280_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) sync_q <= '1;
    else          sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ua280_reset_seq.sv
// Reset sequencer: debounced areq / sw_req, ordered release of NUM_DOMAINS resets.
// Optional sticky reset-cause port under `define UA280_RESET_CAUSE_EN.
module ua280_reset_seq
  import ua280_reset_pkg::*;
#(
  parameter int NUM_DOMAINS   = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 8,
  parameter int GAP_CYCLES    = 16
) (
  input  logic                   clock_i,
  input  logic                   resetn_i,
  input  logic                   areq_i,
  input  logic                   sw_req_i,
  output logic [NUM_DOMAINS-1:0] rst_out_o,
`ifdef UA280_RESET_CAUSE_EN
  output logic [1:0]             cause_o,
`endif
  output logic                   done_o
);

  localparam int CW = DEBOUNCE_BITS + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int IW = idx_w(NUM_DOMAINS);

  localparam logic [CW-1:0] DB_LAST  = {1'b0, {DEBOUNCE_BITS{1'b1}}};
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOMAINS - 1);

  logic                   areq_s;
  logic                   req;
  state_e                 state_q;
  logic [CW-1:0]          db_q;
  logic [GW-1:0]          gap_q;
  logic [IW-1:0]          idx_q;   // next domain to release
  logic [NUM_DOMAINS-1:0] rst_q;
  logic                   done_q;

  ua280_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clock_i),
    .rst_n_i (resetn_i),
    .d_i     (areq_i),
    .q_o     (areq_s)
  );

  assign req = areq_s | sw_req_i;

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q <= ST_HOLD;
      db_q    <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else if (req) begin
      state_q <= ST_HOLD;
      db_q    <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          db_q <= db_q + 1'b1;
          // Last quiet cycle of the debounce window releases domain 0 on this edge.
          if (db_q == DB_LAST) begin
            rst_q <= rst_q << 1;
            gap_q <= '0;
            idx_q <= IW'(1);
            if (NUM_DOMAINS == 1) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_q <= '0;
            rst_q <= rst_q << 1;
            idx_q <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_RUN;
              done_q  <= 1'b1;
            end
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        ST_RUN: ;
        default: state_q <= ST_HOLD;
      endcase
    end
  end

`ifdef UA280_RESET_CAUSE_EN
  cause_e cause_q;

  // Only a fresh re-assertion (leaving RELEASE/RUN) records a cause; HOLD glitches do not.
  always_ff @(posedge clock_i) begin
    if (!resetn_i)
      cause_q <= CAUSE_POR;
    else if (req && state_q != ST_HOLD)
      cause_q <= areq_s ? CAUSE_AREQ : CAUSE_SW;
  end

  assign cause_o = cause_q;
`endif

  assign rst_out_o = rst_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_ua280_reset_seq.sv
// Directed bench for ua280_reset_seq (3 domains, 2 sync stages, 8-cycle debounce, gap 2).
module tb_ua280_reset_seq;

  logic       clk = 1'b0;
  logic       resetn;
  logic       areq;
  logic       sw_req;
  logic [2:0] rst_out;
  logic       done;
`ifdef UA280_RESET_CAUSE_EN
  logic [1:0] cause;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ua280_reset_seq #(
    .NUM_DOMAINS   (3),
    .SYNC_STAGES   (2),
    .DEBOUNCE_BITS (3),
    .GAP_CYCLES    (2)
  ) dut (
    .clock_i   (clk),
    .resetn_i  (resetn),
    .areq_i    (areq),
    .sw_req_i  (sw_req),
    .rst_out_o (rst_out),
`ifdef UA280_RESET_CAUSE_EN
    .cause_o   (cause),
`endif
    .done_o    (done)
  );

  // Expected outputs j edges after the edge that last saw a request.
  function automatic logic [2:0] exp_rst(input int j);
    if (j < 8)       return 3'b111;
    else if (j < 10) return 3'b110;
    else if (j < 12) return 3'b100;
    else             return 3'b000;
  endfunction

  function automatic logic exp_done(input int j);
    return (j >= 12);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_seq(input string tag, input int j);
    chk($sformatf("%s_rst_j%0d", tag, j), {5'd0, rst_out}, {5'd0, exp_rst(j)});
    chk($sformatf("%s_done_j%0d", tag, j), {7'd0, done}, {7'd0, exp_done(j)});
  endtask

  initial begin
    resetn = 1'b0;
    areq   = 1'b0;
    sw_req = 1'b0;

    // Power-on reset, then release sequence.
    repeat (5) tick();
    chk("por_rst", {5'd0, rst_out}, 8'h07);
    chk("por_done", {7'd0, done}, 8'h00);
`ifdef UA280_RESET_CAUSE_EN
    chk("por_cause", {6'd0, cause}, 8'h00);
`endif
    resetn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk_seq("pwr", k - 2);
    end
`ifdef UA280_RESET_CAUSE_EN
    chk("pwr_cause", {6'd0, cause}, 8'h00);
`endif

    // Software request from RUN.
    sw_req = 1'b1;
    for (int j = 0; j <= 13; j++) begin
      tick();
      sw_req = 1'b0;
      chk_seq("sw", j);
`ifdef UA280_RESET_CAUSE_EN
      if (j == 0) chk("sw_cause", {6'd0, cause}, 8'h02);
`endif
    end

    // areq pulse landing while only domain 2 remains in reset.
    sw_req = 1'b1;
    for (int j = 0; j <= 9; j++) begin
      tick();
      sw_req = 1'b0;
    end
    areq = 1'b1;
    tick();
    areq = 1'b0;
    chk("areq_a1", {5'd0, rst_out}, 8'h04);
    tick();
    chk("areq_a2", {5'd0, rst_out}, 8'h04);
    for (int a = 3; a <= 16; a++) begin
      tick();
      chk_seq("areq", a - 3);
`ifdef UA280_RESET_CAUSE_EN
      if (a == 3) chk("areq_cause", {6'd0, cause}, 8'h01);
`endif
    end

    // Periodic glitches keep HOLD from ever completing.
    for (int i = 0; i < 60; i++) begin
      areq = (i % 6 == 0);
      tick();
      if (i + 1 >= 3) begin
        chk($sformatf("glitch_rst_e%0d", i + 1), {5'd0, rst_out}, 8'h07);
        chk($sformatf("glitch_done_e%0d", i + 1), {7'd0, done}, 8'h00);
      end
    end
    areq = 1'b0;
    for (int e = 61; e <= 73; e++) begin
      tick();
      chk_seq("glitch_tail", e - 57);
    end

    // resetn asserted mid-release, then a full power-on sequence.
    sw_req = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      tick();
      sw_req = 1'b0;
    end
    chk("mid_pre_rst", {5'd0, rst_out}, 8'h04);
    resetn = 1'b0;
    tick();
    chk("mid_rst", {5'd0, rst_out}, 8'h07);
    chk("mid_done", {7'd0, done}, 8'h00);
`ifdef UA280_RESET_CAUSE_EN
    chk("mid_cause", {6'd0, cause}, 8'h00);
`endif
    resetn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk_seq("repwr", k - 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
